// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Divide support is selected by the MULDIV_DIV_EN macro in muldiv_seq_unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Width-generic constants are built at the widest supported size and cut down by the user.
    localparam int unsigned MULDIV_MAX_W = 64;

    function automatic logic [MULDIV_MAX_W-1:0] most_neg(input int unsigned w);
        return MULDIV_MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [MULDIV_MAX_W-1:0] all_ones(input int unsigned w);
        return (MULDIV_MAX_W'(1) << w) - MULDIV_MAX_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_sign_conv.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for the sign fix-up of products, quotients and remainders.
module muldiv_sign_conv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);

    always_comb begin
        value_o = negate_i ? (-value_i) : value_i;
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops return 0 on the fast path.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             funct3,
    input  logic [DATA_LENGTH-1:0] op_a,
    input  logic [DATA_LENGTH-1:0] op_b,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_LENGTH-1:0] result
);

    localparam int unsigned N        = DATA_LENGTH;
    localparam int unsigned CNT_W    = $clog2(DATA_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [N-1:0]       a_mag_q, a_mag_d;
    logic [N-1:0]       b_mag_q, b_mag_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [N-1:0]       result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_signed_in, b_signed_in;
    logic               sign_a_in, sign_b_in;
    logic [N-1:0]       a_mag_in, b_mag_in;
    logic [N:0]         mul_sum;
    logic [2*N-1:0]     mul_step, acc_step, prod_fix;
    logic [N-1:0]       mul_res, calc_res;
    logic               fast_path;
    logic [N-1:0]       fast_res;

    always_comb begin
        a_signed_in = funct3[2] ? ~funct3[0] : (funct3 != F3_MULHU);
        b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
        sign_a_in   = a_signed_in & op_a[N-1];
        sign_b_in   = b_signed_in & op_b[N-1];
    end

    muldiv_sign_conv #(.WIDTH(N)) u_conv_a (
        .value_i  (op_a),
        .negate_i (sign_a_in),
        .value_o  (a_mag_in)
    );

    muldiv_sign_conv #(.WIDTH(N)) u_conv_b (
        .value_i  (op_b),
        .negate_i (sign_b_in),
        .value_o  (b_mag_in)
    );

    // Multiply: acc = {partial, multiplier}; add into the top half, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        mul_step = {mul_sum, acc_q[N-1:1]};
    end

    muldiv_sign_conv #(.WIDTH(2*N)) u_fix_prod (
        .value_i  (acc_step),
        .negate_i (sign_a_q ^ sign_b_q),
        .value_o  (prod_fix)
    );

    always_comb begin
        mul_res = (f3_q == F3_MUL) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
    end

`ifdef MULDIV_DIV_EN
    localparam logic [N-1:0] MOST_NEG = N'(most_neg(N));
    localparam logic [N-1:0] ALL_ONES = N'(all_ones(N));

    logic [N:0]     div_rem_sh;
    logic           div_ge;
    logic [N-1:0]   div_rem_nx;
    logic [2*N-1:0] div_step;
    logic [N-1:0]   quo_fix, rem_fix;
    logic           div_by_zero, div_ovf;

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract, restore on borrow.
    always_comb begin
        div_rem_sh = {acc_q[2*N-1:N], acc_q[N-1]};
        div_ge     = (div_rem_sh >= {1'b0, b_mag_q});
        div_rem_nx = div_ge ? N'(div_rem_sh - {1'b0, b_mag_q}) : N'(div_rem_sh);
        div_step   = {div_rem_nx, acc_q[N-2:0], div_ge};
        acc_step   = f3_q[2] ? div_step : mul_step;
    end

    muldiv_sign_conv #(.WIDTH(N)) u_fix_quo (
        .value_i  (acc_step[N-1:0]),
        .negate_i (sign_a_q ^ sign_b_q),
        .value_o  (quo_fix)
    );

    muldiv_sign_conv #(.WIDTH(N)) u_fix_rem (
        .value_i  (acc_step[2*N-1:N]),
        .negate_i (sign_a_q),
        .value_o  (rem_fix)
    );

    always_comb begin
        calc_res    = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix) : mul_res;
        div_by_zero = (op_b == '0);
        div_ovf     = ~funct3[0] & (op_a == MOST_NEG) & (op_b == ALL_ONES);
        fast_path   = funct3[2] & (div_by_zero | div_ovf);
        if (div_by_zero) begin
            fast_res = funct3[1] ? op_a : ALL_ONES;
        end else begin
            fast_res = funct3[1] ? '0 : MOST_NEG;
        end
    end
`else
    always_comb begin
        acc_step  = mul_step;
        calc_res  = mul_res;
        fast_path = funct3[2];
        fast_res  = '0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d     = funct3;
                    a_mag_d  = a_mag_in;
                    b_mag_d  = b_mag_in;
                    sign_a_d = sign_a_in;
                    sign_b_d = sign_b_in;
                    cnt_d    = '0;
                    acc_d    = funct3[2] ? {{N{1'b0}}, a_mag_in} : {{N{1'b0}}, b_mag_in};
                    if (fast_path) begin
                        state_d  = FINISH;
                        result_d = fast_res;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = FINISH;
                    result_d = calc_res;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= F3_MUL;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit (default 32-bit build).
// Divide expectations follow whether MULDIV_DIV_EN is defined for the build.
module tb_muldiv_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total;
    int bad;

    muldiv_seq_unit #(.DATA_LENGTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Issues one operation and waits (bounded) for done. lat counts edges after acceptance.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble,
                          output logic [31:0] res, output int lat, output int nbusy);
        @(negedge clk);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        nbusy = 0;
        res   = 32'hDEAD_BEEF;
        for (int unsigned k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = int'(k);
                res = result;
                break;
            end
            if (busy) nbusy++;
            if (scramble) begin
                op_a   = $urandom;
                op_b   = $urandom;
                funct3 = 3'($urandom);
                start  = ~start;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [2:0]  f3s [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b001, 3'b011};
        logic [31:0] as  [6] = '{32'h7, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h2};
        logic [31:0] exs [6] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h1};
        logic [31:0] res;
        int lat, nb;
        for (int unsigned i = 0; i < 6; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, res, lat, nb);
            total++;
            if (res !== exs[i]) begin bad++; $display("FAIL mul[%0d]_result: got %h want %h", i, res, exs[i]); end
            total++;
            if (lat != 33) begin bad++; $display("FAIL mul[%0d]_latency: got %0d want 33", i, lat); end
            total++;
            if (nb != 33) begin bad++; $display("FAIL mul[%0d]_busy_cycles: got %0d want 33", i, nb); end
            if (i == 0) begin
                @(negedge clk);
                total++;
                if (done !== 1'b0) begin bad++; $display("FAIL mul_done_width: got %b want 0", done); end
                total++;
                if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result_hold: got %h want ffffffeb", result); end
            end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd20, 32'd20};
        logic [31:0] bs  [4] = '{32'd6, 32'd6, 32'd6, 32'd6};
        logic [31:0] exs [4] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'd3, 32'd2};
        logic [31:0] res;
        int lat, nb;
        for (int unsigned i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, res, lat, nb);
            total++;
            if (res !== exs[i]) begin bad++; $display("FAIL div[%0d]_result: got %h want %h", i, res, exs[i]); end
            total++;
            if (lat != 33) begin bad++; $display("FAIL div[%0d]_latency: got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_div_special;
        logic [2:0]  f3s [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exs [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        logic [31:0] res;
        int lat, nb;
        for (int unsigned i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, res, lat, nb);
            total++;
            if (res !== exs[i]) begin bad++; $display("FAIL divspec[%0d]_result: got %h want %h", i, res, exs[i]); end
            total++;
            if (lat != 1) begin bad++; $display("FAIL divspec[%0d]_latency: got %0d want 1", i, lat); end
            total++;
            if (nb != 1) begin bad++; $display("FAIL divspec[%0d]_busy_cycles: got %0d want 1", i, nb); end
        end
    endtask
`else
    task automatic test_div_disabled;
        logic [2:0]  f3s [2] = '{3'b100, 3'b111};
        logic [31:0] as  [2] = '{32'd9, 32'd7};
        logic [31:0] bs  [2] = '{32'd3, 32'd0};
        logic [31:0] res;
        int lat, nb;
        for (int unsigned i = 0; i < 2; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, res, lat, nb);
            total++;
            if (res !== 32'h0) begin bad++; $display("FAIL nodiv[%0d]_result: got %h want 00000000", i, res); end
            total++;
            if (lat != 1) begin bad++; $display("FAIL nodiv[%0d]_latency: got %0d want 1", i, lat); end
            total++;
            if (nb != 1) begin bad++; $display("FAIL nodiv[%0d]_busy_cycles: got %0d want 1", i, nb); end
        end
    endtask
`endif

    task automatic test_operand_hold;
        logic [31:0] res;
        int lat, nb;
        run_op(3'b000, 32'd5, 32'd6, 1'b1, res, lat, nb);
        total++;
        if (res !== 32'd30) begin bad++; $display("FAIL hold_result: got %h want 0000001e", res); end
        total++;
        if (lat != 33) begin bad++; $display("FAIL hold_latency: got %0d want 33", lat); end
    endtask

    task automatic test_abort;
        logic [31:0] res;
        int lat, nb;
        bit saw_done;
        saw_done = 1'b0;
        @(negedge clk);
`ifdef MULDIV_DIV_EN
        funct3 = 3'b100;
`else
        funct3 = 3'b011;
`endif
        op_a  = 32'hFFFFFFEC;
        op_b  = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int unsigned c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            op_a  = $urandom;
            start = c[0];
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL abort_result: got %h want 00000000", result); end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        run_op(3'b000, 32'd3, 32'd4, 1'b0, res, lat, nb);
        total++;
        if (res !== 32'd12) begin bad++; $display("FAIL abort_next_mul: got %h want 0000000c", res); end
        total++;
        if (lat != 33) begin bad++; $display("FAIL abort_next_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        int ndone, t1, t2;
        logic [31:0] r1, r2;
        ndone = 0;
        t1 = -1;
        t2 = -1;
        r1 = '0;
        r2 = '0;
        @(negedge clk);
        funct3 = 3'b000;
        op_a   = 32'd2;
        op_b   = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        op_a = 32'd4;
        op_b = 32'd5;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = c; r1 = result; end
                else begin t2 = c; r2 = result; end
            end
            @(posedge clk);
            #1;
            if (ndone >= 1) start = 1'b0;
        end
        total++;
        if (ndone != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
        total++;
        if (r1 !== 32'd6) begin bad++; $display("FAIL b2b_first_result: got %h want 00000006", r1); end
        total++;
        if (r2 !== 32'd20) begin bad++; $display("FAIL b2b_second_result: got %h want 00000014", r2); end
        total++;
        if (t1 != 34) begin bad++; $display("FAIL b2b_first_done_cycle: got %0d want 34", t1); end
        total++;
        if (t2 - t1 != 34) begin bad++; $display("FAIL b2b_done_spacing: got %0d want 34", t2 - t1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
`ifdef MULDIV_DIV_EN
        test_div();
        test_div_special();
`else
        test_div_disabled();
`endif
        test_operand_hold();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
